// File: rtl/gb_vga_pkg.sv
// Shared constants and types for the Game Boy to VGA path.
// Used by the capture front end and by the downstream VGA framebuffer reader.
// Holds GB screen geometry, framebuffer address width and the pixel shade type.
package gb_vga_pkg;

  localparam int GB_H_ACTIVE = 160;  // GB pixels per line
  localparam int GB_V_ACTIVE = 144;  // GB lines per frame
  localparam int FB_ADDR_W   = 15;   // framebuffer address width, bank bit excluded

  // 2-bit GB pixel shade (0 = lightest, 3 = darkest)
  typedef logic [1:0] shade_t;

  // Capture FSM: waiting for the first frame start, or tracking a frame
  typedef enum logic {
    CAP_SEEK  = 1'b0,
    CAP_FRAME = 1'b1
  } cap_state_t;

endpackage

// File: rtl/sync_edge.sv
// Purpose: 2-FF synchroniser for one asynchronous bit plus history register, with registered rise/fall pulses.
// Latency: a pin edge shows up as a one-cycle rise/fall pulse 3 clk edges later.
// Backpressure: none; free-running, one pulse per detected edge.
// Ports: clk, rst_n (async active-low), d (async input), rise/fall (one-cycle pulses).
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
      rise <= sync & ~hist;
      fall <= ~sync & hist;
    end
  end

endmodule

// File: rtl/gb_capture.sv
// Purpose: capture the raw GB LCD bus in the 25 MHz clk domain and emit framebuffer writes (y*160+x, 2-bit data).
// Latency: gb_px_clk falling edge at the pin -> wr_en high 4 clk edges later (2 sync, 1 edge detect, 1 output reg).
// Backpressure: none; the framebuffer port must accept a write on any cycle (at most one per GB pixel period).
// Ports: clk, rst_n; gb_dat/gb_px_clk/gb_hsync/gb_vsync (async GB bus); wr_en/wr_addr/wr_data (framebuffer write);
//        locked, frame_done, frame_err, line_err (status). Define GB_CAPTURE_DBLBUF_EN for a bank bit in wr_addr
//        and the rd_bank output (last completed bank).
module gb_capture
  import gb_vga_pkg::*;
#(
  parameter int H_ACTIVE = GB_H_ACTIVE,
  parameter int V_ACTIVE = GB_V_ACTIVE,
  parameter int ADDR_W   = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        gb_dat,
  input  logic              gb_px_clk,
  input  logic              gb_hsync,
  input  logic              gb_vsync,
  output logic              wr_en,
`ifdef GB_CAPTURE_DBLBUF_EN
  output logic [ADDR_W:0]   wr_addr,
`else
  output logic [ADDR_W-1:0] wr_addr,
`endif
  output shade_t            wr_data,
  output logic              locked,
  output logic              frame_done,
  output logic              frame_err,
  output logic              line_err
`ifdef GB_CAPTURE_DBLBUF_EN
  ,
  output logic              rd_bank
`endif
);

  localparam logic [7:0] H_LIM = 8'(H_ACTIVE);
  localparam logic [7:0] V_LIM = 8'(V_ACTIVE);

  // Edge detection on the three GB timing signals
  logic px_fall, hs_fall, vs_rise;
  logic unused_px_rise, unused_hs_rise, unused_vs_fall;

  sync_edge u_px_sync (.clk(clk), .rst_n(rst_n), .d(gb_px_clk), .rise(unused_px_rise), .fall(px_fall));
  sync_edge u_hs_sync (.clk(clk), .rst_n(rst_n), .d(gb_hsync),  .rise(unused_hs_rise), .fall(hs_fall));
  sync_edge u_vs_sync (.clk(clk), .rst_n(rst_n), .d(gb_vsync),  .rise(vs_rise),        .fall(unused_vs_fall));

  // Data takes the same three register stages as the pixel clock, so dat_hist
  // holds the value that was on the pins when the pixel clock fell.
  shade_t dat_meta, dat_sync, dat_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_meta <= '0;
      dat_sync <= '0;
      dat_hist <= '0;
    end else begin
      dat_meta <= gb_dat;
      dat_sync <= dat_meta;
      dat_hist <= dat_sync;
    end
  end

  // Frame beats line beats pixel; lower-priority events in the same cycle are dropped.
  logic frame_ev, line_ev, px_ev;
  assign frame_ev = vs_rise;
  assign line_ev  = hs_fall & ~vs_rise;
  assign px_ev    = px_fall & ~hs_fall & ~vs_rise;

  cap_state_t state_q, state_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;  // y*H_ACTIVE, kept incrementally

  logic                     wr_en_d, locked_d, frame_done_d, frame_err_d, line_err_d;
  logic [$bits(wr_addr)-1:0] wr_addr_d;
  shade_t                   wr_data_d;

`ifdef GB_CAPTURE_DBLBUF_EN
  logic bank_q, bank_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CAP_SEEK;
    else        state_q <= state_d;
  end

  // Next state: once a frame start is seen the block never leaves FRAME (only reset does)
  always_comb begin
    state_d = state_q;
    if (frame_ev) state_d = CAP_FRAME;
  end

  // Outputs and counters
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    base_d       = base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    locked_d     = locked;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    line_err_d   = 1'b0;
`ifdef GB_CAPTURE_DBLBUF_EN
    bank_d       = bank_q;
`endif
    if (frame_ev) begin
      if ((state_q == CAP_FRAME) && (y_q != V_LIM)) frame_err_d = 1'b1;
      x_d      = '0;
      y_d      = '0;
      base_d   = '0;
      locked_d = 1'b1;
    end else if (state_q == CAP_FRAME) begin
      if (line_ev) begin
        // A latch with no pixels since the last one is a duplicate/blank line
        if (x_q != 8'd0) begin
          x_d    = '0;
          y_d    = (y_q == 8'hFF) ? y_q : y_q + 8'd1;
          base_d = base_q + ADDR_W'(H_ACTIVE);
          if ((y_q != 8'hFF) && (y_q + 8'd1 == V_LIM)) begin
            frame_done_d = 1'b1;
`ifdef GB_CAPTURE_DBLBUF_EN
            bank_d = ~bank_q;
`endif
          end
        end
      end else if (px_ev) begin
        if ((x_q < H_LIM) && (y_q < V_LIM)) begin
          wr_en_d   = 1'b1;
`ifdef GB_CAPTURE_DBLBUF_EN
          wr_addr_d = {bank_q, base_q + ADDR_W'(x_q)};
`else
          wr_addr_d = base_q + ADDR_W'(x_q);
`endif
          wr_data_d = dat_hist;
          x_d       = x_q + 8'd1;
        end else begin
          line_err_d = 1'b1;
          if (x_q != 8'hFF) x_d = x_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      base_q     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      base_q     <= base_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      locked     <= locked_d;
      frame_done <= frame_done_d;
      frame_err  <= frame_err_d;
      line_err   <= line_err_d;
    end
  end

`ifdef GB_CAPTURE_DBLBUF_EN
  // rd_bank follows the bank that has just been completed, so the reader never sees a frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q  <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      bank_q <= bank_d;
      if (frame_done_d) rd_bank <= bank_q;
    end
  end
`endif

endmodule

// File: doc/gb_capture.md
# gb_capture

Front-end capture stage of the Game Boy to VGA path. Samples the raw Game Boy LCD bus (2-bit pixel data, pixel clock, HSYNC, VSYNC) inside the 25 MHz VGA clock domain and turns it into a framebuffer write stream of 160x144 2-bit pixels. The VGA pixel generator downstream reads the framebuffer. This block is the only place the asynchronous GB signals enter the design.

## Interface
- `H_ACTIVE`, default 160: GB pixels per line.
- `V_ACTIVE`, default 144: GB lines per frame.
- `ADDR_W`, default 15: framebuffer address width, excluding the bank bit.

- `clk` in 1: 25 MHz VGA pixel clock (PLL output). The block has one clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `gb_dat` in 2: GB pixel data. Asynchronous to `clk`.
- `gb_px_clk` in 1: GB pixel clock. Asynchronous.
- `gb_hsync` in 1: GB line latch pulse. Asynchronous.
- `gb_vsync` in 1: GB frame start. Asynchronous.
- `wr_en` out 1: framebuffer write strobe, one `clk` wide.
- `wr_addr` out `ADDR_W`(+1): pixel address y*160+x. The MSB is the bank bit when double buffering is enabled.
- `wr_data` out 2: pixel value.
- `locked` out 1: high once a frame start has been seen.
- `frame_done` out 1: one-cycle pulse after line `V_ACTIVE-1` completes.
- `frame_err` out 1: one-cycle pulse when a frame start arrives with a line count other than `V_ACTIVE`.
- `line_err` out 1: one-cycle pulse for a pixel edge with x ≥ `H_ACTIVE` or y ≥ `V_ACTIVE`.

## Operation
- Synchronisation: `gb_px_clk`, `gb_hsync`, `gb_vsync` and `gb_dat` each pass through two flip-flops, then one history register for edge detection. `gb_dat` gets the same depth so it stays aligned with the pixel clock.
- Events, evaluated per `clk`:
  - pixel event: falling edge of synchronised `gb_px_clk`.
  - line event: falling edge of `gb_hsync`.
  - frame event: rising edge of `gb_vsync`.
- States:
  - SEEK: reset state. Pixel and line events are ignored. A frame event sets x=0, y=0, line_base=0 and moves to FRAME. `locked` goes to 1 and stays 1 until reset.
  - FRAME:
    - pixel event with x<`H_ACTIVE` and y<`V_ACTIVE`: write `wr_data`=sampled data at `wr_addr`=line_base+x, then x++.
    - pixel event otherwise: `line_err` pulses, no write, x saturates.
    - line event with x≠0: x=0, y++, line_base += `H_ACTIVE`. If the new y equals `V_ACTIVE`, `frame_done` pulses.
    - line event with x==0: ignored (duplicate or blank latch).
    - frame event: if y≠`V_ACTIVE`, `frame_err` pulses. Then counters reset as in SEEK. The state stays FRAME.
- Simultaneous events in one cycle, priority frame > line > pixel. A lower-priority event in the same cycle is dropped.
- Widths: x is 8 bits, y is 8 bits, line_base is `ADDR_W` bits. There is no multiplier. The largest address is 23039.
- Reset mid-frame: all state clears immediately, the block returns to SEEK, and it does not write until the next frame event.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `locked`=0, `frame_done`=0, `frame_err`=0, `line_err`=0. Bank=0 when enabled.
- Latency: a `gb_px_clk` falling edge at the pin produces `wr_en` high 4 `clk` edges later: 2 sync, 1 edge detect, 1 registered output.
- All outputs are registered. `wr_addr`/`wr_data` are only meaningful while `wr_en`=1.
- Throughput: at most one write per GB pixel period (about 6 `clk` at 4.19 MHz). There is no backpressure: the framebuffer port must accept a write every cycle.
- `frame_done`, `frame_err` and `line_err` each pulse for exactly one cycle.

## Configuration
- `GB_CAPTURE_DBLBUF_EN` defined:
  - `wr_addr` gains an MSB bank bit, toggled on each `frame_done`.
  - The output `rd_bank` (1 bit) exposes the last completed bank, so the VGA side reads a stable frame.
  - A frame ended by `frame_err` does not toggle the bank.
- Undefined: single buffer. `wr_addr` is `ADDR_W` bits and `rd_bank` is absent.

## Structure
- Shared package `gb_vga_pkg`: `GB_H_ACTIVE`=160, `GB_V_ACTIVE`=144, `FB_ADDR_W`=15, and the 2-bit pixel shade type. The downstream VGA reader uses the same constants.
- One sub-module: `sync_edge`, a 2-FF synchroniser plus history register with rise/fall outputs. It is instantiated three times, once each for the pixel clock, HSYNC and VSYNC.
- The capture FSM and counters live in `gb_capture`.

## Test plan
- Pixels before the first VSYNC: 200 `gb_px_clk` falls before any VSYNC → no `wr_en`, `locked`=0.
- Full frame: VSYNC rise, 144 lines of 160 pixels with data = x[1:0] →
  - 23040 writes;
  - last write at addr 23039 with data 3;
  - one `frame_done`, no errors.
- Long line: 162 pixels on line 5 → 160 writes (addr 800..959) and 2 `line_err` pulses; line 6 starts at addr 960.
- Short frame: VSYNC after 100 lines → `frame_err` pulse; the next write is at addr 0.
- Latency/reset: `wr_en` appears 4 clk after the pin edge. Asserting `rst_n` low mid-line forces all outputs to 0, and no write occurs until the next VSYNC rise.
- With `GB_CAPTURE_DBLBUF_EN`: over two good frames, `wr_addr` MSB is 0 then 1, and `rd_bank` reads 0 after the first `frame_done`. A short frame leaves the bank unchanged.
